// File: rtl/pc_fetch_sequencer_pkg.sv
// pc_fetch_sequencer_pkg: shared transfer kinds, reset PC and fetch FSM encoding.
package pc_fetch_sequencer_pkg;
  localparam logic [2:0] PCOP_NORMAL = 3'd0;
  localparam logic [2:0] PCOP_BR_T = 3'd1;
  localparam logic [2:0] PCOP_BR_NT = 3'd2;
  localparam logic [2:0] PCOP_J = 3'd3;
  localparam logic [2:0] PCOP_JR = 3'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_e;
endpackage

// File: rtl/pc_fetch_sequencer_target_gen.sv
// pc_target_gen: combinational control-transfer target from the ID-stage fields.
module pc_target_gen
  import pc_fetch_sequencer_pkg::*;
(
  input  logic [2:0]  pc_op_i,
  input  logic [31:0] pc4_i,
  input  logic [31:0] imm_i,
  input  logic [25:0] index_i,
  input  logic [31:0] rs_i,
  output logic [31:0] target_o,
  output logic        valid_o
);
  assign valid_o = pc_op_i inside {PCOP_BR_T, PCOP_BR_NT, PCOP_J, PCOP_JR};
  assign target_o = (pc_op_i == PCOP_BR_T)  ? pc4_i + {imm_i[29:0], 2'b00} :
                    (pc_op_i == PCOP_BR_NT) ? pc4_i + 32'd4 :
                    (pc_op_i == PCOP_J)     ? {pc4_i[31:28], index_i, 2'b00} : rs_i;
endmodule

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: owns the PC, fetches over req/ready, skids across stalls and
// applies ID-resolved redirects after the delay-slot fetch completes.
module pc_fetch_sequencer
  import pc_fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_redirect,
  input  logic [2:0]  id_pc_op,
  input  logic [31:0] id_pc4,
  input  logic [31:0] id_imm,
  input  logic [25:0] id_index,
  input  logic [31:0] id_rs,
  output logic        pc_misaligned
);
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, ptgt_q, ptgt_d, sinstr_q, sinstr_d, spc_q, spc_d;
  logic        pend_q, pend_d, tvalid, done, accept;
  logic [31:0] tgt;

  pc_target_gen u_tgt (
    .pc_op_i(id_pc_op), .pc4_i(id_pc4), .imm_i(id_imm), .index_i(id_index),
    .rs_i(id_rs), .target_o(tgt), .valid_o(tvalid)
  );

  assign imem_req = !reset && state_q == FETCH;
  assign done = imem_req && imem_ready;
  assign accept = !reset && id_redirect && !stall && tvalid;
  assign imem_addr = pc_q;
  assign pc_misaligned = |pc_q[1:0];
  assign if_valid = !reset && (state_q == HOLD || imem_ready);
  assign if_instr = (state_q == HOLD) ? sinstr_q : imem_rdata;
  assign if_pc = (state_q == HOLD) ? spc_q : pc_q;

  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    pend_d = pend_q;
    ptgt_d = ptgt_q;
    sinstr_d = sinstr_q;
    spc_d = spc_q;
    if (done) begin
      pc_d = pend_q ? ptgt_q : (accept ? tgt : pc_q + 32'd4);
      pend_d = 1'b0;
    end else if (accept) begin
      pend_d = 1'b1;
      ptgt_d = tgt;
    end
    // a word completing under stall is parked so IF/ID sees it when stall drops
    if (done && stall) begin
      state_d = HOLD;
      sinstr_d = imem_rdata;
      spc_d = pc_q;
    end
    if (state_q == HOLD && !stall) state_d = FETCH;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q <= RESET_PC;
      pend_q <= 1'b0;
      ptgt_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      pend_q <= pend_d;
      ptgt_q <= ptgt_d;
    end
    sinstr_q <= sinstr_d;
    spc_q <= spc_d;
  end
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer: directed test-plan scenarios plus random traffic against a fetch model.
module tb_pc_fetch_sequencer;
  logic        clk = 1'b0, reset, stall, imem_req, imem_ready, if_valid;
  logic        id_redirect, pc_misaligned;
  logic [31:0] imem_addr, imem_rdata, if_instr, if_pc, id_pc4, id_imm, id_rs;
  logic [2:0]  id_pc_op;
  logic [25:0] id_index;
  int          n_tests = 0, n_fail = 0;

  logic [31:0] m_pc = 32'h3000, m_ptgt = 0, m_sinstr = 0, m_spc = 0;
  bit          m_pend = 0, m_hold = 0;

  pc_fetch_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .if_valid(if_valid),
    .if_instr(if_instr), .if_pc(if_pc), .id_redirect(id_redirect), .id_pc_op(id_pc_op),
    .id_pc4(id_pc4), .id_imm(id_imm), .id_index(id_index), .id_rs(id_rs),
    .pc_misaligned(pc_misaligned)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] target(input logic [2:0] op, input logic [31:0] pc4,
                                         input logic [31:0] imm, input logic [25:0] idx,
                                         input logic [31:0] rs);
    case (op)
      3'd1: return pc4 + imm * 4;
      3'd2: return pc4 + 4;
      3'd3: return (pc4 & 32'hF000_0000) | ({6'd0, idx} * 4);
      default: return rs;
    endcase
  endfunction

  // drive one cycle, check outputs against the model, then advance the model
  task automatic cyc(input bit rst, input bit rdy, input bit stl, input bit rd,
                     input logic [2:0] op, input logic [31:0] pc4, input logic [31:0] imm,
                     input logic [25:0] idx, input logic [31:0] rs);
    logic [31:0] w, nxt;
    bit fetched, taken;
    @(negedge clk);
    w = $urandom;
    reset = rst; imem_ready = rdy; stall = stl; id_redirect = rd; id_pc_op = op;
    id_pc4 = pc4; id_imm = imm; id_index = idx; id_rs = rs; imem_rdata = w;
    #1;
    chk("imem_req", {31'd0, imem_req}, {31'd0, !rst && !m_hold});
    chk("if_valid", {31'd0, if_valid}, {31'd0, !rst && (m_hold || rdy)});
    if (!rst) begin
      chk("imem_addr", imem_addr, m_pc);
      chk("pc_misaligned", {31'd0, pc_misaligned}, {31'd0, m_pc[1:0] != 2'b00});
      if (m_hold || rdy) begin
        chk("if_instr", if_instr, m_hold ? m_sinstr : w);
        chk("if_pc", if_pc, m_hold ? m_spc : m_pc);
      end
    end
    if (rst) begin
      m_pc = 32'h3000; m_pend = 0; m_hold = 0;
    end else begin
      fetched = !m_hold && rdy;
      taken = rd && !stl && op >= 3'd1 && op <= 3'd4;
      if (m_hold && !stl) m_hold = 0;
      if (fetched) begin
        nxt = m_pend ? m_ptgt : taken ? target(op, pc4, imm, idx, rs) : m_pc + 4;
        if (stl) begin
          m_hold = 1; m_sinstr = w; m_spc = m_pc;
        end
        m_pc = nxt;
        m_pend = 0;
      end else if (taken) begin
        m_pend = 1;
        m_ptgt = target(op, pc4, imm, idx, rs);
      end
    end
  endtask

  task automatic run(input bit rdy, input bit stl);
    cyc(0, rdy, stl, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("reset req", {31'd0, imem_req}, 0);
    run(1, 0); chk("free 0", imem_addr, 32'h3000);
    run(1, 0); chk("free 1", imem_addr, 32'h3004);
    cyc(0, 1, 0, 1, 3'd1, 32'h3008, 32'd4, 0, 0);
    chk("delay slot", imem_addr, 32'h3008);
    run(1, 0); chk("branch tgt", imem_addr, 32'h3018);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) run(1, 0);
    cyc(0, 0, 0, 1, 3'd3, 32'h3010, 0, 26'h0000C40, 0);
    run(0, 0); run(0, 0);
    run(1, 0); chk("jump delay slot pc", if_pc, 32'h3010);
    run(0, 0); chk("jump tgt", imem_addr, 32'h3100);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    run(1, 0);
    run(1, 1); chk("stall cap pc", if_pc, 32'h3004);
    run(0, 1); chk("hold pc", if_pc, 32'h3004); chk("hold req", {31'd0, imem_req}, 0);
    chk("hold addr", imem_addr, 32'h3008);
    run(1, 0); chk("hold release pc", if_pc, 32'h3004);
    run(1, 0); chk("after stall", imem_addr, 32'h3008);
    cyc(0, 1, 0, 1, 3'd4, 32'h300C, 0, 0, 32'h3002);
    run(0, 0); chk("jr tgt", imem_addr, 32'h3002); chk("misaligned", {31'd0, pc_misaligned}, 1);
    cyc(0, 1, 0, 1, 3'd0, 32'h3006, 32'd100, 0, 32'h4000);
    run(0, 0); chk("op0 no redirect", imem_addr, 32'h3006);
    cyc(0, 0, 0, 1, 3'd3, 32'h300A, 0, 26'h123, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    run(0, 0); chk("rst pend pc", imem_addr, 32'h3000); chk("rst pend valid", {31'd0, if_valid}, 0);
    run(1, 0);
    run(0, 0); chk("pend discarded", imem_addr, 32'h3004);
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rs;
      rs = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 4) == 0,
          $urandom_range(0, 5) == 0, 3'($urandom_range(0, 7)), $urandom,
          $urandom_range(0, 1) ? $urandom : 32'($signed(8'($urandom))),
          26'($urandom), rs);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
